// File: rtl/minterm_scanner.sv
// minterm_scanner: sweeps a 4-input function stage through all 16 input
// combinations, captures F per index and checks it against a minterm mask.
`default_nettype none

module minterm_scanner #(
   parameter logic [15:0] EXPECTED = 16'h0DD0,
   parameter int          SETTLE   = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   output logic        en_out,
   output logic        a,
   output logic        b,
   output logic        c,
   output logic        d,
   input  logic        f_in,
   output logic        busy,
   output logic        done,
   output logic [15:0] map,
   output logic        pass,
   output logic [4:0]  mismatch_cnt,
   output logic [3:0]  first_fail
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_SCAN = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [3:0] C_LAST = 4'(SETTLE - 1);

   logic [1:0]  state_q, state_d;
   logic [3:0]  idx_q, idx_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [15:0] map_q, map_d;
   logic [4:0]  mcnt_q, mcnt_d;
   logic [3:0]  ff_q, ff_d;
   logic        seen_q, seen_d;
   logic        pass_q, pass_d;

   logic        w_sample;
   logic        w_miss;

   assign w_sample = (state_q == S_SCAN) && (cnt_q == C_LAST);
   assign w_miss   = (f_in != EXPECTED[idx_q]);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         idx_q   <= 4'd0;
         cnt_q   <= 4'd0;
         map_q   <= 16'd0;
         mcnt_q  <= 5'd0;
         ff_q    <= 4'd0;
         seen_q  <= 1'b0;
         pass_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         map_q   <= map_d;
         mcnt_q  <= mcnt_d;
         ff_q    <= ff_d;
         seen_q  <= seen_d;
         pass_q  <= pass_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start) state_d = S_SCAN;
         S_SCAN:  if (w_sample && (idx_q == 4'd15)) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      idx_d  = idx_q;
      cnt_d  = cnt_q;
      map_d  = map_q;
      mcnt_d = mcnt_q;
      ff_d   = ff_q;
      seen_d = seen_q;
      pass_d = pass_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               idx_d  = 4'd0;
               cnt_d  = 4'd0;
               map_d  = 16'd0;
               mcnt_d = 5'd0;
               ff_d   = 4'd0;
               seen_d = 1'b0;
               pass_d = 1'b0;
            end
         end
         S_SCAN: begin
            if (w_sample) begin
               map_d[idx_q] = f_in;
               if (w_miss) begin
                  mcnt_d = mcnt_q + 5'd1;
                  if (!seen_q) begin
                     ff_d   = idx_q;
                     seen_d = 1'b1;
                  end
               end
               cnt_d = 4'd0;
               // Verdict must include the mismatch found on this final sample.
               if (idx_q == 4'd15) pass_d = (mcnt_q == 5'd0) && !w_miss;
               else                idx_d  = idx_q + 4'd1;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      en_out       = (state_q == S_SCAN);
      busy         = (state_q == S_SCAN);
      done         = (state_q == S_DONE);
      {a, b, c, d} = (state_q == S_SCAN) ? idx_q : 4'd0;
      map          = map_q;
      pass         = pass_q;
      mismatch_cnt = mcnt_q;
      first_fail   = ff_q;
   end

endmodule

`default_nettype wire

// File: tb/tb_minterm_scanner.sv
// Directed bench for minterm_scanner: combinational, stuck, inverted and
// pipelined function stages, mid-scan reset and start-handshake corners.
`default_nettype none

module tb_minterm_scanner;

   localparam logic [15:0] C_EXP = 16'h0DD0;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int n_pass  = 0;
   int n_total = 0;

   // SETTLE=1 instance with selectable stage behaviour
   logic        s1 = 1'b0;
   logic [1:0]  mode = 2'd0;
   logic        en1, a1, b1, c1, d1, f1, busy1, done1, pass1;
   logic [15:0] map1;
   logic [4:0]  mc1;
   logic [3:0]  ff1;
   logic        g1;
   assign g1 = en1 & C_EXP[{a1, b1, c1, d1}];
   assign f1 = (mode == 2'd0) ? g1 : (mode == 2'd1) ? 1'b0 : ~g1;

   minterm_scanner #(.EXPECTED(C_EXP), .SETTLE(1)) u1 (
      .clk(clk), .rst_n(rst_n), .start(s1), .en_out(en1),
      .a(a1), .b(b1), .c(c1), .d(d1), .f_in(f1), .busy(busy1), .done(done1),
      .map(map1), .pass(pass1), .mismatch_cnt(mc1), .first_fail(ff1));

   // SETTLE=3 and SETTLE=2 instances, each behind a two-flop stage
   logic        s23 = 1'b0;
   logic        en3, a3, b3, c3, d3, busy3, done3, pass3;
   logic        en2, a2, b2, c2, d2, busy2, done2, pass2;
   logic [15:0] map3, map2;
   logic [4:0]  mc3, mc2;
   logic [3:0]  ff3, ff2;
   logic        p3a, p3b, p2a, p2b;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p3a <= 1'b0; p3b <= 1'b0; p2a <= 1'b0; p2b <= 1'b0;
      end else begin
         p3a <= en3 & C_EXP[{a3, b3, c3, d3}];
         p3b <= p3a;
         p2a <= en2 & C_EXP[{a2, b2, c2, d2}];
         p2b <= p2a;
      end
   end

   minterm_scanner #(.EXPECTED(C_EXP), .SETTLE(3)) u3 (
      .clk(clk), .rst_n(rst_n), .start(s23), .en_out(en3),
      .a(a3), .b(b3), .c(c3), .d(d3), .f_in(p3b), .busy(busy3), .done(done3),
      .map(map3), .pass(pass3), .mismatch_cnt(mc3), .first_fail(ff3));

   minterm_scanner #(.EXPECTED(C_EXP), .SETTLE(2)) u2 (
      .clk(clk), .rst_n(rst_n), .start(s23), .en_out(en2),
      .a(a2), .b(b2), .c(c2), .d(d2), .f_in(p2b), .busy(busy2), .done(done2),
      .map(map2), .pass(pass2), .mismatch_cnt(mc2), .first_fail(ff2));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start1();
      s1 = 1'b1;
      tick();
      s1 = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      tick(); tick();
      chk("rst_busy", 32'(busy1), 32'd0);
      chk("rst_en", 32'(en1), 32'd0);
      chk("rst_done", 32'(done1), 32'd0);
      chk("rst_map", 32'(map1), 32'd0);
      chk("rst_pass", 32'(pass1), 32'd0);
      rst_n = 1'b1;
      tick();

      // Correct combinational stage
      mode = 2'd0;
      start1();
      chk("t1_busy0", 32'(busy1), 32'd1);
      chk("t1_en0", 32'(en1), 32'd1);
      chk("t1_idx0", 32'({a1, b1, c1, d1}), 32'd0);
      for (int k = 1; k < 16; k++) begin
         tick();
         chk("t1_idx", 32'({a1, b1, c1, d1}), 32'(k));
         chk("t1_nodone", 32'(done1), 32'd0);
      end
      tick();
      chk("t1_done", 32'(done1), 32'd1);
      chk("t1_busy", 32'(busy1), 32'd0);
      chk("t1_en", 32'(en1), 32'd0);
      chk("t1_abcd", 32'({a1, b1, c1, d1}), 32'd0);
      chk("t1_map", 32'(map1), 32'h0DD0);
      chk("t1_pass", 32'(pass1), 32'd1);
      chk("t1_mc", 32'(mc1), 32'd0);
      chk("t1_ff", 32'(ff1), 32'd0);
      tick();
      chk("t1_donepulse", 32'(done1), 32'd0);
      chk("t1_maphold", 32'(map1), 32'h0DD0);

      // Stuck-at-0 stage
      mode = 2'd1;
      tick();
      start1();
      repeat (16) tick();
      chk("t2_done", 32'(done1), 32'd1);
      chk("t2_map", 32'(map1), 32'h0000);
      chk("t2_pass", 32'(pass1), 32'd0);
      chk("t2_mc", 32'(mc1), 32'd6);
      chk("t2_ff", 32'(ff1), 32'd4);

      // Inverted stage
      mode = 2'd2;
      tick();
      start1();
      repeat (16) tick();
      chk("t3_done", 32'(done1), 32'd1);
      chk("t3_map", 32'(map1), 32'hF22F);
      chk("t3_pass", 32'(pass1), 32'd0);
      chk("t3_mc", 32'(mc1), 32'd16);
      chk("t3_ff", 32'(ff1), 32'd0);

      // Two-flop stage: SETTLE=3 passes, SETTLE=2 sees F of the previous index
      tick();
      s23 = 1'b1;
      tick();
      s23 = 1'b0;
      repeat (32) tick();
      chk("t4_s2_done", 32'(done2), 32'd1);
      chk("t4_s2_map", 32'(map2), 32'h1BA0);
      chk("t4_s2_mc", 32'(mc2), 32'd6);
      chk("t4_s2_pass", 32'(pass2), 32'd0);
      repeat (15) tick();
      chk("t4_s3_nodone", 32'(done3), 32'd0);
      chk("t4_s3_busy", 32'(busy3), 32'd1);
      tick();
      chk("t4_s3_done", 32'(done3), 32'd1);
      chk("t4_s3_map", 32'(map3), 32'h0DD0);
      chk("t4_s3_pass", 32'(pass3), 32'd1);
      chk("t4_s3_mc", 32'(mc3), 32'd0);

      // Asynchronous reset at idx 7
      mode = 2'd2;
      tick();
      start1();
      repeat (7) tick();
      chk("t5_idx7", 32'({a1, b1, c1, d1}), 32'd7);
      chk("t5_map7", 32'(map1), 32'h002F);
      chk("t5_mc7", 32'(mc1), 32'd7);
      #2 rst_n = 1'b0;
      #1;
      chk("t5_busy", 32'(busy1), 32'd0);
      chk("t5_en", 32'(en1), 32'd0);
      chk("t5_abcd", 32'({a1, b1, c1, d1}), 32'd0);
      chk("t5_map", 32'(map1), 32'd0);
      chk("t5_mc", 32'(mc1), 32'd0);
      tick();
      rst_n = 1'b1;
      mode = 2'd0;
      tick();
      start1();
      chk("t5_idx0", 32'({a1, b1, c1, d1}), 32'd0);
      repeat (16) tick();
      chk("t5_done", 32'(done1), 32'd1);
      chk("t5_pass", 32'(pass1), 32'd1);
      chk("t5_map2", 32'(map1), 32'h0DD0);

      // start held high across a scan
      tick();
      s1 = 1'b1;
      tick();
      repeat (8) tick();
      chk("t6_idx8", 32'({a1, b1, c1, d1}), 32'd8);
      repeat (8) tick();
      chk("t6_done", 32'(done1), 32'd1);
      s1 = 1'b0;
      tick();
      chk("t6_busy17", 32'(busy1), 32'd0);
      tick();
      chk("t6_busy18", 32'(busy1), 32'd0);

      // Pulses in SCAN and DONE ignored; start right after done accepted
      start1();
      repeat (5) tick();
      s1 = 1'b1;
      tick();
      s1 = 1'b0;
      chk("t7_idx6", 32'({a1, b1, c1, d1}), 32'd6);
      repeat (9) tick();
      chk("t7_idx15", 32'({a1, b1, c1, d1}), 32'd15);
      tick();
      chk("t7_done", 32'(done1), 32'd1);
      chk("t7_nobusy", 32'(busy1), 32'd0);
      s1 = 1'b1;
      tick();
      chk("t7_ignored", 32'(busy1), 32'd0);
      chk("t7_hold", 32'(map1), 32'h0DD0);
      tick();
      s1 = 1'b0;
      chk("t7_accept", 32'(busy1), 32'd1);
      chk("t7_mapclr", 32'(map1), 32'd0);
      chk("t7_passclr", 32'(pass1), 32'd0);
      repeat (16) tick();
      chk("t7_done2", 32'(done1), 32'd1);
      chk("t7_pass2", 32'(pass1), 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

`default_nettype wire
